// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its requester arbiter:
// command encoding, arbiter FSM state encoding and operand width.
package alu_pkg;

   localparam int OPW = 32;

   typedef enum logic [2:0] {
      CMD_ADD  = 3'd0,
      CMD_SUB  = 3'd1,
      CMD_XOR  = 3'd2,
      CMD_SLT  = 3'd3,
      CMD_AND  = 3'd4,
      CMD_NAND = 3'd5,
      CMD_NOR  = 3'd6,
      CMD_OR   = 3'd7
   } alu_cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } arb_state_e;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU. Overflow is reported for signed ADD only;
// SLT is an unsigned compare producing 0 or 1.
module alu
   import alu_pkg::*;
(
   input  logic [OPW-1:0] a_i,
   input  logic [OPW-1:0] b_i,
   input  logic [2:0]     cmd_i,
   output logic [OPW-1:0] result_o,
   output logic           iszero_o,
   output logic           overflow_o
);

   logic [OPW-1:0] sum;
   logic [OPW-1:0] diff;

   assign sum  = a_i + b_i;
   assign diff = a_i - b_i;

   // Operation select and ADD overflow detection
   always_comb begin
      result_o   = '0;
      overflow_o = 1'b0;
      case (alu_cmd_e'(cmd_i))
         CMD_ADD: begin
            result_o   = sum;
            overflow_o = (a_i[OPW-1] == b_i[OPW-1]) && (sum[OPW-1] != a_i[OPW-1]);
         end
         CMD_SUB:  result_o = diff;
         CMD_XOR:  result_o = a_i ^ b_i;
         CMD_SLT:  result_o = {{(OPW-1){1'b0}}, (a_i < b_i)};
         CMD_AND:  result_o = a_i & b_i;
         CMD_NAND: result_o = ~(a_i & b_i);
         CMD_NOR:  result_o = ~(a_i | b_i);
         CMD_OR:   result_o = a_i | b_i;
         default:  result_o = '0;
      endcase
   end

   assign iszero_o = (result_o == '0);

endmodule

// File: rtl/rr_pick.sv
// Combinational one-hot picker: starting at ptr_i and wrapping modulo
// NREQ, grants the first set bit of req_i. Tying ptr_i to 0 turns it
// into a lowest-index-wins priority encoder.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IDW-1:0]  idx_o,
   output logic            any_o
);

   logic [IDW:0] cand;

   // Scan requesters in priority order ptr, ptr+1, ... and take the first
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      cand  = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, ptr_i} + (IDW+1)'(k);
         if (cand >= (IDW+1)'(NREQ)) begin
            cand = cand - (IDW+1)'(NREQ);
         end
         if (!any_o && req_i[cand[IDW-1:0]]) begin
            any_o                = 1'b1;
            gnt_o[cand[IDW-1:0]] = 1'b1;
            idx_o                = cand[IDW-1:0];
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NREQ requesters. Sequence per operation:
// IDLE (grant + capture operands) -> EXEC (ALU runs, result captured)
// -> RESP (hold response until the granted requester accepts it).
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise the
// lowest-index valid requester always wins.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int  NREQ = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic [NREQ-1:0]     req_valid_i,
   output logic [NREQ-1:0]     req_ready_o,
   input  logic [NREQ*OPW-1:0] req_opa_i,
   input  logic [NREQ*OPW-1:0] req_opb_i,
   input  logic [NREQ*3-1:0]   req_cmd_i,
   output logic [NREQ-1:0]     rsp_valid_o,
   input  logic [NREQ-1:0]     rsp_ready_i,
   output logic [OPW-1:0]      rsp_result_o,
   output logic                rsp_iszero_o,
   output logic                rsp_overflow_o,
   output logic                busy_o
);

   arb_state_e state_q, state_d;

   logic [OPW-1:0] opa_arr [NREQ];
   logic [OPW-1:0] opb_arr [NREQ];
   logic [2:0]     cmd_arr [NREQ];

   logic [NREQ-1:0] pick_gnt;
   logic [IDW-1:0]  pick_idx;
   logic            pick_any;
   logic [IDW-1:0]  ptr_w;
   logic            accept;

   logic [OPW-1:0] iss_opa_q;
   logic [OPW-1:0] iss_opb_q;
   logic [2:0]     iss_cmd_q;
   logic [IDW-1:0] iss_idx_q;

   logic [OPW-1:0] rsp_res_q;
   logic           rsp_zero_q;
   logic           rsp_ovf_q;
   logic [IDW-1:0] rsp_idx_q;

   logic [OPW-1:0] alu_res;
   logic           alu_zero;
   logic           alu_ovf;

   // Split the packed request buses into per-requester lanes
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
      assign opa_arr[gi] = req_opa_i[gi*OPW +: OPW];
      assign opb_arr[gi] = req_opb_i[gi*OPW +: OPW];
      assign cmd_arr[gi] = req_cmd_i[gi*3 +: 3];
   end

`ifdef ALU_ARB_RR_EN
   logic [IDW-1:0] ptr_q, ptr_d;

   assign ptr_d = (pick_idx == IDW'(NREQ-1)) ? '0 : pick_idx + IDW'(1);
   assign ptr_w = ptr_q;

   // Priority pointer moves just past each granted requester
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ptr_q <= '0;
      end else if (accept) begin
         ptr_q <= ptr_d;
      end
   end
`else
   assign ptr_w = '0;
`endif

   rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .req_i (req_valid_i),
      .ptr_i (ptr_w),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   alu u_alu (
      .a_i        (iss_opa_q),
      .b_i        (iss_opb_q),
      .cmd_i      (iss_cmd_q),
      .result_o   (alu_res),
      .iszero_o   (alu_zero),
      .overflow_o (alu_ovf)
   );

   // FSM state register
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, grant and response-valid decode; grant is held off during reset
   always_comb begin
      state_d     = state_q;
      req_ready_o = '0;
      rsp_valid_o = '0;
      accept      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!reset_i && pick_any) begin
               req_ready_o = pick_gnt;
               accept      = 1'b1;
               state_d     = ST_EXEC;
            end
         end
         ST_EXEC: state_d = ST_RESP;
         ST_RESP: begin
            rsp_valid_o[rsp_idx_q] = 1'b1;
            if (rsp_ready_i[rsp_idx_q]) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Issue registers load on grant; response registers load at the end of EXEC
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         iss_opa_q  <= '0;
         iss_opb_q  <= '0;
         iss_cmd_q  <= '0;
         iss_idx_q  <= '0;
         rsp_res_q  <= '0;
         rsp_zero_q <= 1'b0;
         rsp_ovf_q  <= 1'b0;
         rsp_idx_q  <= '0;
      end else begin
         if (accept) begin
            iss_opa_q <= opa_arr[pick_idx];
            iss_opb_q <= opb_arr[pick_idx];
            iss_cmd_q <= cmd_arr[pick_idx];
            iss_idx_q <= pick_idx;
         end
         if (state_q == ST_EXEC) begin
            rsp_res_q  <= alu_res;
            rsp_zero_q <= alu_zero;
            rsp_ovf_q  <= alu_ovf;
            rsp_idx_q  <= iss_idx_q;
         end
      end
   end

   assign rsp_result_o   = rsp_res_q;
   assign rsp_iszero_o   = rsp_zero_q;
   assign rsp_overflow_o = rsp_ovf_q;
   assign busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: reset state, arbitration order,
// constant ALU vectors, backpressure, reset during EXEC and a random
// phase checked against a behavioural model. Follows ALU_ARB_RR_EN.
module tb_alu_arbiter;

   localparam int NREQ = 4;

   logic                clk;
   logic                reset;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ*32-1:0]  opa;
   logic [NREQ*32-1:0]  opb;
   logic [NREQ*3-1:0]   cmd;
   logic [NREQ-1:0]     rsp_valid;
   logic [NREQ-1:0]     rsp_ready;
   logic [31:0]         rsp_result;
   logic                rsp_iszero;
   logic                rsp_overflow;
   logic                busy;

   int errors = 0;
   int checks = 0;
   int mptr   = 0;

   alu_arbiter #(.NREQ(NREQ)) dut (
      .clk_i          (clk),
      .reset_i        (reset),
      .req_valid_i    (req_valid),
      .req_ready_o    (req_ready),
      .req_opa_i      (opa),
      .req_opb_i      (opb),
      .req_cmd_i      (cmd),
      .rsp_valid_o    (rsp_valid),
      .rsp_ready_i    (rsp_ready),
      .rsp_result_o   (rsp_result),
      .rsp_iszero_o   (rsp_iszero),
      .rsp_overflow_o (rsp_overflow),
      .busy_o         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          idx;
      logic [2:0]  c;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_r;
      logic        exp_z;
      logic        exp_o;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference ALU from the arithmetic definitions: {overflow, zero, result}
   function automatic logic [33:0] ref_alu(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      logic        o;
      longint      sa, sb, s;
      longint      lim_hi, lim_lo;
      lim_hi = 64'sh7FFFFFFF;
      lim_lo = -64'sh80000000;
      sa = $signed(a);
      sb = $signed(b);
      s  = sa + sb;
      o  = 1'b0;
      case (c)
         3'd0: begin r = a + b; o = (s > lim_hi) || (s < lim_lo); end
         3'd1: r = a - b;
         3'd2: r = a ^ b;
         3'd3: r = (a < b) ? 32'd1 : 32'd0;
         3'd4: r = a & b;
         3'd5: r = ~(a & b);
         3'd6: r = ~(a | b);
         default: r = a | b;
      endcase
      return {o, (r == 32'd0), r};
   endfunction

   // Which requester the arbitration rules select from a valid mask
   function automatic int model_pick(input logic [NREQ-1:0] v);
      for (int k = 0; k < NREQ; k++) begin
         int c;
         c = (mptr + k) % NREQ;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   task automatic load(input int r, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
      opa[r*32 +: 32] = a;
      opb[r*32 +: 32] = b;
      cmd[r*3 +: 3]   = c;
   endtask

   // One full grant/exec/response transaction starting in IDLE
   task automatic serve(input int stall, input bit keep, output logic [NREQ-1:0] gnt_seen,
                        output logic [31:0] res, output logic z, output logic o);
      int          g;
      logic [33:0] exp;
      logic [31:0] a, b;
      logic [2:0]  c;
      #1;
      g = model_pick(req_valid);
      gnt_seen = req_ready;
      res = '0; z = 1'b0; o = 1'b0;
      if (g < 0) begin
         checks++;
         errors++;
         $display("FAIL serve: no pending request in model");
         return;
      end
      chk("grant", 32'(req_ready), 32'(1) << g);
      a   = opa[g*32 +: 32];
      b   = opb[g*32 +: 32];
      c   = cmd[g*3 +: 3];
      exp = ref_alu(c, a, b);
`ifdef ALU_ARB_RR_EN
      mptr = (g + 1) % NREQ;
`endif
      tick();
      if (!keep) req_valid[g] = 1'b0;
      rsp_ready = (stall == 0) ? '1 : ~(NREQ'(1) << g);
      #1;
      chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("exec_req_ready", 32'(req_ready), 32'd0);
      chk("exec_busy", 32'(busy), 32'd1);
      tick();
      chk("resp_valid", 32'(rsp_valid), 32'(1) << g);
      chk("resp_result", rsp_result, exp[31:0]);
      chk("resp_iszero", 32'(rsp_iszero), 32'(exp[32]));
      chk("resp_overflow", 32'(rsp_overflow), 32'(exp[33]));
      res = rsp_result;
      z   = rsp_iszero;
      o   = rsp_overflow;
      for (int s = 1; s < stall; s++) begin
         tick();
         chk("stall_valid", 32'(rsp_valid), 32'(1) << g);
         chk("stall_result", rsp_result, exp[31:0]);
         chk("stall_req_ready", 32'(req_ready), 32'd0);
      end
      if (stall > 0) rsp_ready = NREQ'(1) << g;
      tick();
      rsp_ready = '0;
      #1;
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      $display("txn req=%0d cmd=%0d a=%h b=%h result=%h z=%0b o=%0b stall=%0d",
               g, c, a, b, res, z, o, stall);
   endtask

   initial begin
      vec_t              vecs[13];
      int                order_exp[5];
      logic [NREQ-1:0]   gs;
      logic [31:0]       r;
      logic              z, o;

      vecs[0]  = '{2, 3'd0, 32'd5,         32'd7,         32'd12,        1'b0, 1'b0};
      vecs[1]  = '{1, 3'd0, 32'h7FFFFFFF,  32'd1,         32'h80000000,  1'b0, 1'b1};
      vecs[2]  = '{3, 3'd1, 32'd9,         32'd9,         32'd0,         1'b1, 1'b0};
      vecs[3]  = '{0, 3'd3, 32'd3,         32'd5,         32'd1,         1'b0, 1'b0};
      vecs[4]  = '{0, 3'd3, 32'd5,         32'd3,         32'd0,         1'b1, 1'b0};
      vecs[5]  = '{1, 3'd3, 32'd1,         32'hFFFFFFFF,  32'd1,         1'b0, 1'b0};
      vecs[6]  = '{2, 3'd2, 32'hF0F0F0F0,  32'hFF00FF00,  32'h0FF00FF0,  1'b0, 1'b0};
      vecs[7]  = '{3, 3'd4, 32'hF0F0F0F0,  32'hFF00FF00,  32'hF000F000,  1'b0, 1'b0};
      vecs[8]  = '{0, 3'd5, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'd0,         1'b1, 1'b0};
      vecs[9]  = '{1, 3'd6, 32'd0,         32'd0,         32'hFFFFFFFF,  1'b0, 1'b0};
      vecs[10] = '{2, 3'd7, 32'h12340000,  32'h00005678,  32'h12345678,  1'b0, 1'b0};
      vecs[11] = '{3, 3'd1, 32'h80000000,  32'd1,         32'h7FFFFFFF,  1'b0, 1'b0};
      vecs[12] = '{0, 3'd0, 32'hFFFFFFFF,  32'd1,         32'd0,         1'b1, 1'b0};

`ifdef ALU_ARB_RR_EN
      order_exp = '{0, 1, 2, 3, 0};
`else
      order_exp = '{0, 0, 0, 0, 0};
`endif

      // Reset with every requester asking
      reset     = 1'b1;
      req_valid = '1;
      rsp_ready = '0;
      for (int i = 0; i < NREQ; i++) load(i, 3'd0, 32'(i), 32'd10);
      tick();
      tick();
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_result", rsp_result, 32'd0);
      chk("rst_iszero", 32'(rsp_iszero), 32'd0);
      chk("rst_overflow", 32'(rsp_overflow), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      mptr  = 0;
      #1;
      chk("first_grant", 32'(req_ready), 32'd1);

      // Arbitration order with all requesters held valid
      for (int i = 0; i < 5; i++) begin
         serve(0, 1'b1, gs, r, z, o);
         chk("arb_order", 32'(gs), 32'(1) << order_exp[i]);
      end
      req_valid = '0;

      // Constant vectors, one requester at a time
      for (int i = 0; i < 13; i++) begin
         req_valid = NREQ'(1) << vecs[i].idx;
         load(vecs[i].idx, vecs[i].c, vecs[i].a, vecs[i].b);
         serve(0, 1'b0, gs, r, z, o);
         chk("vec_result", r, vecs[i].exp_r);
         chk("vec_iszero", 32'(z), 32'(vecs[i].exp_z));
         chk("vec_overflow", 32'(o), 32'(vecs[i].exp_o));
      end

      // Backpressure: 5 cycles with rsp_ready low, then immediate regrant
      req_valid = 4'b0011;
      load(0, 3'd2, 32'hAAAA5555, 32'h0F0F0F0F);
      load(1, 3'd0, 32'd100, 32'd23);
      serve(5, 1'b0, gs, r, z, o);
      serve(0, 1'b0, gs, r, z, o);

      // Reset while in EXEC discards the transaction
      req_valid = 4'b0100;
      load(2, 3'd0, 32'd1, 32'd1);
      #1;
      chk("rx_grant", 32'(req_ready), 32'h4);
      tick();
      reset     = 1'b1;
      req_valid = '0;
      rsp_ready = '1;
      #1;
      chk("rx_exec_busy", 32'(busy), 32'd1);
      tick();
      reset     = 1'b0;
      mptr      = 0;
      req_valid = 4'b1010;
      #1;
      chk("rx_after_busy", 32'(busy), 32'd0);
      chk("rx_after_valid", 32'(rsp_valid), 32'd0);
      chk("rx_after_grant", 32'(req_ready), 32'h2);
      req_valid = '0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rx_no_rsp", 32'(rsp_valid), 32'd0);
         chk("rx_idle", 32'(busy), 32'd0);
      end
      rsp_ready = '0;

      // Random traffic against the model
      for (int it = 0; it < 40; it++) begin
         for (int q = 0; q < NREQ; q++) begin
            if (!req_valid[q] && ($urandom_range(0, 1) == 1)) begin
               req_valid[q] = 1'b1;
               load(q, 3'($urandom_range(0, 7)), $urandom, $urandom);
               if ($urandom_range(0, 3) == 0) opb[q*32 +: 32] = opa[q*32 +: 32];
            end
         end
         if (req_valid == '0) begin
            int q;
            q = $urandom_range(0, NREQ-1);
            req_valid[q] = 1'b1;
            load(q, 3'($urandom_range(0, 7)), $urandom, $urandom);
         end
         serve($urandom_range(0, 3), 1'b0, gs, r, z, o);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
